// File: rtl/decodificacao_pipe_pkg.sv
// Shared RV32I decode definitions: format codes, opcodes, field extraction and immediate assembly.
package decodificacao_pipe_pkg;

  localparam logic [2:0] TIPO_I   = 3'd0;
  localparam logic [2:0] TIPO_U   = 3'd1;
  localparam logic [2:0] TIPO_S   = 3'd2;
  localparam logic [2:0] TIPO_R   = 3'd3;
  localparam logic [2:0] TIPO_INV = 3'd4;
  localparam logic [2:0] TIPO_SB  = 3'd6;
  localparam logic [2:0] TIPO_UJ  = 3'd7;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [2:0] tipo;
  } campos_t;

  function automatic logic [2:0] tipo_de(input logic [6:0] opc);
    logic [2:0] t;
    case (opc)
      OPC_LOAD, OPC_OPIMM, OPC_JALR: t = TIPO_I;
      OPC_LUI, OPC_AUIPC:            t = TIPO_U;
      OPC_STORE:                     t = TIPO_S;
      OPC_OP:                        t = TIPO_R;
      OPC_BRANCH:                    t = TIPO_SB;
      OPC_JAL:                       t = TIPO_UJ;
      default:                       t = TIPO_INV;
    endcase
    return t;
  endfunction

  // Register/function fields, zeroed wherever the format does not carry them.
  function automatic campos_t decodifica_campos(input logic [31:0] instr);
    campos_t c;
    c        = '0;
    c.opcode = instr[6:0];
    c.tipo   = tipo_de(instr[6:0]);
    case (c.tipo)
      TIPO_I: begin
        c.rd     = instr[11:7];
        c.rs1    = instr[19:15];
        c.funct3 = instr[14:12];
      end
      TIPO_U, TIPO_UJ: c.rd = instr[11:7];
      TIPO_S, TIPO_SB: begin
        c.rs1    = instr[19:15];
        c.rs2    = instr[24:20];
        c.funct3 = instr[14:12];
      end
      TIPO_R: begin
        c.rd     = instr[11:7];
        c.rs1    = instr[19:15];
        c.rs2    = instr[24:20];
        c.funct3 = instr[14:12];
        c.funct7 = instr[31:25];
      end
      default: c.tipo = TIPO_INV;
    endcase
    return c;
  endfunction

  // Immediate as a 32-bit value whose bit 31 is always instr[31]; callers sign-extend to XLEN.
  function automatic logic [31:0] imediato32(input logic [31:0] instr, input logic [2:0] tipo);
    logic [31:0] imm;
    case (tipo)
      TIPO_I:  imm = {{20{instr[31]}}, instr[31:20]};
      TIPO_S:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      TIPO_SB: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      TIPO_U:  imm = {instr[31:12], 12'b0};
      TIPO_UJ: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decodificacao_pipe_fila_instrucoes.sv
// Synchronous FIFO of {pc, instr} entries feeding the decode stage.
module fila_instrucoes #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/decodificacao_pipe.sv
// RV32I decode stage: instruction FIFO, combinational decode of the FIFO head, registered output slot.
// Optional DECODE_ILLEGAL_EN passes unknown opcodes through flagged as illegal instead of dropping them.
module decodificacao_pipe
  import decodificacao_pipe_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_instr,
  input  logic [XLEN-1:0]               in_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_pc,
  output logic [6:0]                    opcode,
  output logic [4:0]                    rd,
  output logic [4:0]                    rs1,
  output logic [4:0]                    rs2,
  output logic [2:0]                    funct3,
  output logic [6:0]                    funct7,
  output logic [XLEN-1:0]               immediate,
  output logic [2:0]                    tipo,
  output logic                          illegal,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned EW = XLEN + 32;

  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [EW-1:0]   head;
  logic [31:0]     head_instr;
  logic [XLEN-1:0] head_pc;
  campos_t         campos;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  logic            keep;

  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = !empty && (!out_valid || out_ready) && !flush;

  fila_instrucoes #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fila (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({in_pc, in_instr}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign head_instr = head[31:0];
  assign head_pc    = head[EW-1:32];

  always_comb begin
    campos  = decodifica_campos(head_instr);
    imm32   = imediato32(head_instr, campos.tipo);
    imm_ext = XLEN'($signed(imm32));
`ifdef DECODE_ILLEGAL_EN
    keep    = 1'b1;
`else
    keep    = (campos.tipo != TIPO_INV);
`endif
  end

  // Output slot: loads on pop, holds under backpressure, empties when drained or dropped.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      opcode    <= '0;
      rd        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      funct3    <= '0;
      funct7    <= '0;
      immediate <= '0;
      tipo      <= '0;
    end else if (pop && keep) begin
      out_valid <= 1'b1;
      out_pc    <= head_pc;
      opcode    <= campos.opcode;
      rd        <= campos.rd;
      rs1       <= campos.rs1;
      rs2       <= campos.rs2;
      funct3    <= campos.funct3;
      funct7    <= campos.funct7;
      immediate <= imm_ext;
      tipo      <= campos.tipo;
    end else if (pop || out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DECODE_ILLEGAL_EN
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      illegal <= 1'b0;
    end else if (pop) begin
      illegal <= (campos.tipo == TIPO_INV);
    end
  end
`else
  assign illegal = 1'b0;
`endif

endmodule
